cacheline_arbiter: RTL

- Shares the single physical-memory cacheline port between the instruction cache (read-only) and the data cache (read/write). Sits between the two caches and the cacheline adaptor.
- Serialises requests, holding exactly one memory transaction in flight at a time.
- Uses round-robin or fixed-priority arbitration, and latches address, data and operation at grant time.

---
 rtl/cacheline_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/cacheline_arbiter.sv
// Purpose: shares one physical-memory cacheline port between the I-cache (read-only) and the D-cache (read/write).
// Latency: strobe one cycle after a request is seen in IDLE; resp one cycle after pmem_resp; next grant one cycle later.
// Backpressure: requests are levels held until resp; one transaction in flight; BUSY waits on pmem_resp indefinitely.
module cacheline_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 256,
    parameter int FIXED_DPRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state;
    logic   last_grant;   // 1 = data cache was granted last
    logic   owner;        // 1 = data cache owns the transaction
    logic   op_write;
    logic   i_pend;
    logic   d_pend;
    logic   grant_d;

    // Pick the winner among pending requesters; round-robin toggles against last_grant on ties.
    always_comb begin
        i_pend = i_read;
        d_pend = d_read | d_write;
        if (i_pend && d_pend) begin
            grant_d = (FIXED_DPRIO != 0) ? 1'b1 : ~last_grant;
        end else begin
            grant_d = d_pend;
        end
    end

    // Transaction FSM: grant and latch in IDLE, hold strobes in BUSY, pulse the owner's resp in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            op_write     <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            i_resp       <= 1'b0;
            d_resp       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    i_resp <= 1'b0;
                    d_resp <= 1'b0;
                    if (i_pend || d_pend) begin
                        owner        <= grant_d;
                        last_grant   <= grant_d;
                        op_write     <= grant_d & d_write;
                        pmem_address <= grant_d ? d_address : i_address;
                        if (grant_d && d_write) begin
                            pmem_wdata <= d_wdata;
                        end
                        // d_write wins over d_read when both are raised
                        pmem_read    <= ~(grant_d & d_write);
                        pmem_write   <= grant_d & d_write;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        if (!op_write) begin
                            if (owner) begin
                                d_rdata <= pmem_rdata;
                            end else begin
                                i_rdata <= pmem_rdata;
                            end
                        end
                        i_resp <= ~owner;
                        d_resp <= owner;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    i_resp <= 1'b0;
                    d_resp <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
